mux_sequencer: RTL and testbench
================================

# mux_sequencer

Column-multiplexing sequencer driving the eight LED-line gate signals (`gpio_0` mux pins) downstream of `driver_controller`. On each `column_ready` edge it blanks all lines for a programmable dead time, then enables the next line. `position_sync` realigns the sequence to line 0. It runs on `clock_66`. Its `column_ready` and `position_sync` inputs come from the `clock_33` domain, which is phase-locked to `clock_66`, so only edge detection is needed.

## Interface
- `N_LINES`, default 8: number of multiplexed lines; must be ≥2.
- `DEAD_TIME`, default 4: `clock_66` cycles with all lines off between two active lines; must be ≥1.
- `clock_66` (in, 1): clock.
- `nrst` (in, 1): reset, asynchronous, active-low.
- `enable` (in, 1): level; low forces every line off and returns the block to IDLE. Connected to `rgb_enable`.
- `column_ready` (in, 1): from `driver_controller`. A rising edge means new column data is latched.
- `position_sync` (in, 1): start of revolution. A rising edge resynchronises the sequence.
- `mux_out` (out, N_LINES): one-hot active-high line enable, or all zero.
- `line_idx` (out, $clog2(N_LINES)): index of the current or next line.
- `frame_start` (out, 1): one-cycle pulse when line 0 turns on.
- `overrun` (out, 1): sticky error flag; a `column_ready` edge arrived during dead time.

## Operation
- Edge detect:
  - `cr_q` and `ps_q` are registered copies of the inputs.
  - `cr_edge = column_ready & ~cr_q` and `ps_edge = position_sync & ~ps_q`.
  - Both register copies reset to 0, so an input held high through reset does not produce an edge.
- FSM states: IDLE, WAIT_SYNC, DEAD, ON.
  - IDLE: `mux_out = 0`. Moves to WAIT_SYNC when `enable = 1`.
  - WAIT_SYNC: `mux_out = 0`, `column_ready` edges are ignored. On `ps_edge`: `line_idx ← 0`, dead counter ← DEAD_TIME−1, go to DEAD.
  - DEAD: `mux_out = 0`. The counter decrements each cycle. In the cycle the counter reads 0, go to ON.
  - ON: `mux_out = 1 << line_idx`.
    - On `cr_edge`: `line_idx ← (line_idx == N_LINES−1) ? 0 : line_idx+1` (wrap-around), counter ← DEAD_TIME−1, go to DEAD.
    - On `ps_edge`: `line_idx ← 0`, counter reload, go to DEAD.
- Priority:
  1. `enable = 0` overrides everything. It forces IDLE and `mux_out = 0`, and clears `overrun` and `line_idx`.
  2. `ps_edge` beats `cr_edge` in the same cycle. The sequence goes to line 0 and the column edge is dropped.
- Overrun:
  - A `cr_edge` in DEAD sets `overrun` and is otherwise ignored. The index does not advance twice.
  - A `ps_edge` in DEAD restarts DEAD with `line_idx = 0` and does not set `overrun`.
- `frame_start`: 1 for exactly the first ON cycle with `line_idx = 0`, whatever the cause (sync or wrap).
- All outputs are registered. `mux_out` is glitch-free, and the one-hot invariant holds every cycle.

## Timing
- Reset values: state IDLE, `mux_out = 0`, `line_idx = 0`, `frame_start = 0`, `overrun = 0`, dead counter 0, `cr_q`/`ps_q` = 0.
- Edge-to-off latency: `cr_edge` sampled at rising clock edge t gives `mux_out = 0` from cycle t+1.
- Off duration: exactly DEAD_TIME cycles (t+1 … t+DEAD_TIME).
- New line on at cycle t+DEAD_TIME+1. Total edge-to-on latency is DEAD_TIME+1.
- `enable` falling: `mux_out = 0` in the next cycle.
- `enable` rising: IDLE → WAIT_SYNC after 1 cycle. `ps_edge` is honoured from the first WAIT_SYNC cycle.
- Reset asserted mid-ON: `mux_out` goes to 0 asynchronously.
- Minimum `column_ready` period without overrun: DEAD_TIME+1 `clock_66` cycles.

## Structure
- Shared package `spirose_pkg`:
  - the state enum `mux_state_t` {IDLE, WAIT_SYNC, DEAD, ON};
  - constants `MUX_N_LINES = 8` and `MUX_DEAD_TIME = 4`, used by the top level.
- One sub-module, `rise_detect`: a register plus an AND-NOT gate, instantiated twice (`column_ready`, `position_sync`).
- The FSM, counter and index live in `mux_sequencer` itself.
- Top-level integration: `mux_out[7:0]` replaces the `sw[9:2]` drive on `gpio_0[10..24]`.

## Test plan
- Reset and idle: `nrst` low, then high with `enable = 0` and a `column_ready` toggling every 10 cycles → `mux_out = 0`, `line_idx = 0`, `overrun = 0` throughout.
- Sync start: `enable = 1`, `ps_edge` at cycle 5 (DEAD_TIME = 4) → `mux_out = 0` in cycles 6–9; `mux_out = 8'h01` and a single-cycle `frame_start` at cycle 10.
- Full rotation and wrap: `column_ready` edge every 20 cycles → `mux_out` sequence 01, 02, 04, … 80, 01, with a 4-cycle all-zero gap before each line. `frame_start` pulses only on the return to 01.
- Overrun: a `column_ready` edge 2 cycles after the previous one (inside DEAD) → `overrun = 1` and stays set. The index advances only once; `enable` low clears the flag.
- Simultaneous events: `ps_edge` and `cr_edge` in the same cycle while on line 5 → the next line on is 0, `overrun` remains 0.
- Disable and reset mid-line: drop `enable` while `mux_out = 8'h10` → 0 next cycle, state IDLE. Assert `nrst` low while a line is on → `mux_out = 0` immediately, before the next clock edge.

Source files
------------

// File: rtl/spirose_pkg.sv
// spirose_pkg: shared types and constants for the column-multiplexing path.
//   mux_state_t   - sequencer FSM states (IDLE, WAIT_SYNC, DEAD, ON)
//   MUX_N_LINES   - number of LED gate lines driven from gpio_0
//   MUX_DEAD_TIME - clock_66 cycles with every line off between two lines
package spirose_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        DEAD      = 2'd2,
        ON        = 2'd3
    } mux_state_t;

    localparam int MUX_N_LINES   = 8;
    localparam int MUX_DEAD_TIME = 4;

endpackage

// File: rtl/mux_sequencer_if.sv
// mux_sequencer_if: control inputs and line outputs of the mux sequencer.
//   enable        - level, low forces all lines off and the sequencer to IDLE
//   column_ready  - rising edge = new column latched by driver_controller
//   position_sync - rising edge = start of revolution, realign to line 0
//   mux_out       - one-hot line enable (or all zero)
//   line_idx      - index of the current or next line
//   frame_start   - one-cycle pulse when line 0 turns on
//   overrun       - sticky, a column edge arrived during dead time
// Handshake semantics: there is no valid/ready pair. The master raises
// column_ready / position_sync as levels from the phase-locked clock_33
// domain; only their rising edges carry meaning and each edge is consumed
// exactly once by the slave. Outputs are registered and carry no handshake.
interface mux_sequencer_if #(
    parameter int N_LINES = spirose_pkg::MUX_N_LINES
);
    localparam int IDX_W = $clog2(N_LINES);

    logic               enable;
    logic               column_ready;
    logic               position_sync;
    logic [N_LINES-1:0] mux_out;
    logic [IDX_W-1:0]   line_idx;
    logic               frame_start;
    logic               overrun;

    modport master (
        output enable, column_ready, position_sync,
        input  mux_out, line_idx, frame_start, overrun
    );

    modport slave (
        input  enable, column_ready, position_sync,
        output mux_out, line_idx, frame_start, overrun
    );

endinterface

// File: rtl/mux_sequencer_rise_detect.sv
// rise_detect: registered copy of a level plus AND-NOT, giving a one-cycle
// rise pulse. The copy resets to 0 so a level held high through reset
// produces no pulse.
//   clock_66 - clock
//   nrst     - asynchronous active-low reset
//   din      - level input (phase-locked source, no synchroniser needed)
//   rise     - din & ~previous din
module rise_detect (
    input  logic clock_66,
    input  logic nrst,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clock_66 or negedge nrst) begin
        if (!nrst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/mux_sequencer.sv
// mux_sequencer: column-multiplexing sequencer for the LED gate lines.
// Each column_ready edge blanks all lines for DEAD_TIME cycles and then
// enables the next line; position_sync realigns the sequence to line 0.
//   clock_66  - clock
//   nrst      - asynchronous active-low reset
//   bus       - mux_sequencer_if slave (enable, edges in; line outputs out)
//   state_dbg - current FSM state, for observation only
module mux_sequencer
    import spirose_pkg::*;
#(
    parameter int N_LINES   = MUX_N_LINES,
    parameter int DEAD_TIME = MUX_DEAD_TIME
) (
    input  logic             clock_66,
    input  logic             nrst,
    mux_sequencer_if.slave   bus,
    output mux_state_t       state_dbg
);

    localparam int IDX_W = $clog2(N_LINES);
    localparam int CNT_W = $clog2(DEAD_TIME + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_LINES - 1);
    localparam logic [CNT_W-1:0]   RELOAD   = CNT_W'(DEAD_TIME - 1);
    localparam logic [N_LINES-1:0] LINE0    = N_LINES'(1);

    logic cr_edge;
    logic ps_edge;

    rise_detect u_cr_rise (
        .clock_66 (clock_66),
        .nrst     (nrst),
        .din      (bus.column_ready),
        .rise     (cr_edge)
    );

    rise_detect u_ps_rise (
        .clock_66 (clock_66),
        .nrst     (nrst),
        .din      (bus.position_sync),
        .rise     (ps_edge)
    );

    mux_state_t         state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [N_LINES-1:0] mux_q, mux_n;
    logic               frame_q, frame_n;
    logic               ov_q, ov_n;

    always_ff @(posedge clock_66 or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            mux_q   <= '0;
            frame_q <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            mux_q   <= mux_n;
            frame_q <= frame_n;
            ov_q    <= ov_n;
        end
    end

    // mux_out is computed one cycle ahead and registered, so the line
    // pattern changes only on clock edges and is always one-hot or zero.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        mux_n   = mux_q;
        frame_n = 1'b0;
        ov_n    = ov_q;

        if (!bus.enable) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
            mux_n   = '0;
            ov_n    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mux_n   = '0;
                    state_n = WAIT_SYNC;
                end
                WAIT_SYNC: begin
                    mux_n = '0;
                    if (ps_edge) begin
                        idx_n   = '0;
                        cnt_n   = RELOAD;
                        state_n = DEAD;
                    end
                end
                DEAD: begin
                    mux_n = '0;
                    if (ps_edge) begin
                        // Resync restarts the blanking window on line 0.
                        idx_n = '0;
                        cnt_n = RELOAD;
                    end else begin
                        // A column edge here is flagged but never advances
                        // the index a second time.
                        if (cr_edge) begin
                            ov_n = 1'b1;
                        end
                        if (cnt == '0) begin
                            state_n = ON;
                            mux_n   = LINE0 << idx;
                            frame_n = (idx == '0);
                        end else begin
                            cnt_n = cnt - 1'b1;
                        end
                    end
                end
                ON: begin
                    if (ps_edge) begin
                        idx_n   = '0;
                        cnt_n   = RELOAD;
                        mux_n   = '0;
                        state_n = DEAD;
                    end else if (cr_edge) begin
                        idx_n   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
                        cnt_n   = RELOAD;
                        mux_n   = '0;
                        state_n = DEAD;
                    end
                end
                default: begin
                    state_n = IDLE;
                    mux_n   = '0;
                end
            endcase
        end
    end

    assign bus.mux_out     = mux_q;
    assign bus.line_idx    = idx;
    assign bus.frame_start = frame_q;
    assign bus.overrun     = ov_q;
    assign state_dbg       = state;

endmodule

// File: tb/tb_mux_sequencer.sv
// tb_mux_sequencer: stimulus table, directed corner sequences and random
// traffic for mux_sequencer, checked against a countdown-based model.
module tb_mux_sequencer;
    import spirose_pkg::*;

    localparam int N = MUX_N_LINES;
    localparam int D = MUX_DEAD_TIME;

    logic       clock_66 = 1'b0;
    logic       nrst     = 1'b0;
    mux_state_t state_dbg;

    mux_sequencer_if #(.N_LINES(N)) bus ();

    mux_sequencer #(.N_LINES(N), .DEAD_TIME(D)) dut (
        .clock_66  (clock_66),
        .nrst      (nrst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clock_66 = ~clock_66;

    int n_tests = 0;
    int n_fail  = 0;

    logic [N-1:0] one = 1;

    // Reference model: "remaining off cycles" view of the sequence.
    bit m_armed, m_synced, m_ov, m_frame, p_cr, p_ps;
    int m_off, m_line;

    logic rcr = 1'b0;
    logic rps = 1'b0;
    logic ren;

    typedef struct {
        logic       en, cr, ps;
        logic [7:0] mux;
        logic [2:0] idx;
        logic       fs, ov;
    } vec_t;

    vec_t tbl[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_synced = 0; m_ov = 0; m_frame = 0;
        p_cr = 0; p_ps = 0; m_off = 0; m_line = 0;
    endtask

    task automatic model_step(input logic en, input logic cr, input logic ps);
        logic cre, pse;
        cre = cr & ~p_cr;
        pse = ps & ~p_ps;
        p_cr = cr;
        p_ps = ps;
        m_frame = 0;
        if (!en) begin
            m_armed = 0; m_synced = 0; m_off = 0; m_line = 0; m_ov = 0;
        end else if (!m_armed) begin
            m_armed = 1;
        end else if (!m_synced) begin
            if (pse) begin m_synced = 1; m_line = 0; m_off = D; end
        end else if (pse) begin
            m_line = 0; m_off = D;
        end else if (m_off > 0) begin
            if (cre) m_ov = 1;
            m_off--;
            if (m_off == 0) m_frame = (m_line == 0);
        end else if (cre) begin
            m_line = (m_line + 1) % N;
            m_off  = D;
        end
    endtask

    task automatic compare_model();
        logic [N-1:0] e_mux;
        e_mux = (m_synced && m_off == 0) ? (one << m_line) : '0;
        check("mux_out", bus.mux_out, e_mux);
        check("line_idx", bus.line_idx, m_line);
        check("frame_start", bus.frame_start, m_frame);
        check("overrun", bus.overrun, m_ov);
        check("onehot", ($countones(bus.mux_out) <= 1), 1);
    endtask

    // Called at a falling edge: drive, let one rising edge pass, compare.
    task automatic cycle(input logic en, input logic cr, input logic ps);
        bus.enable        = en;
        bus.column_ready  = cr;
        bus.position_sync = ps;
        @(posedge clock_66);
        model_step(en, cr, ps);
        @(negedge clock_66);
        compare_model();
    endtask

    task automatic advance_lines(input int count, input int period);
        for (int k = 0; k < count; k++) begin
            for (int j = 0; j < period; j++) begin
                cycle(1'b1, (j < period / 2), 1'b0);
            end
        end
    endtask

    initial begin
        // en cr ps | mux idx fs ov
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd2, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 8'h04, 3'd2, 1'b0, 1'b1};
        tbl[18] = '{1'b1, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};

        bus.enable        = 1'b0;
        bus.column_ready  = 1'b0;
        bus.position_sync = 1'b0;
        model_reset();

        // Clock and reset
        repeat (3) @(negedge clock_66);
        check("rst_mux", bus.mux_out, 0);
        check("rst_idx", bus.line_idx, 0);
        check("rst_frame", bus.frame_start, 0);
        check("rst_ov", bus.overrun, 0);
        check("rst_state", state_dbg, IDLE);
        nrst = 1'b1;

        // Idle with column_ready toggling every 10 cycles
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, ((i / 10) % 2) == 1, 1'b0);
        end
        check("idle_state", state_dbg, IDLE);

        // Table: sync start, two advances, overrun, simultaneous, disable
        for (int i = 0; i < 21; i++) begin
            cycle(tbl[i].en, tbl[i].cr, tbl[i].ps);
            check("tbl_mux", bus.mux_out, tbl[i].mux);
            check("tbl_idx", bus.line_idx, tbl[i].idx);
            check("tbl_frame", bus.frame_start, tbl[i].fs);
            check("tbl_ov", bus.overrun, tbl[i].ov);
        end

        // Full rotation with wrap, column edge every 20 cycles
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
        check("rot_start", bus.mux_out, 8'h01);
        for (int k = 0; k < 9; k++) begin
            int zeros, frames;
            zeros  = 0;
            frames = 0;
            for (int j = 0; j < 20; j++) begin
                cycle(1'b1, (j < 10), 1'b0);
                if (bus.mux_out == '0) zeros++;
                if (bus.frame_start) frames++;
            end
            check("rot_line", bus.mux_out, one << ((k + 1) % N));
            check("rot_gap", zeros, D);
            check("rot_frame", frames, (((k + 1) % N) == 0) ? 1 : 0);
        end

        // Simultaneous sync and column edge while on line 5
        advance_lines(4, 8);
        check("sim_line5", bus.mux_out, 8'h20);
        cycle(1'b1, 1'b1, 1'b1);
        check("sim_idx", bus.line_idx, 0);
        for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, 1'b0);
        check("sim_mux", bus.mux_out, 8'h01);
        check("sim_frame", bus.frame_start, 1);
        check("sim_ov", bus.overrun, 0);

        // Disable while line 4 is on
        advance_lines(4, 8);
        check("dis_before", bus.mux_out, 8'h10);
        cycle(1'b0, 1'b0, 1'b0);
        check("dis_mux", bus.mux_out, 0);
        check("dis_state", state_dbg, IDLE);

        // Asynchronous reset while a line is on
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0);
        check("arst_before", bus.mux_out, 8'h01);
        #2 nrst = 1'b0;
        #1;
        check("arst_mux", bus.mux_out, 0);
        check("arst_state", state_dbg, IDLE);
        model_reset();
        bus.position_sync = 1'b0;
        repeat (2) @(negedge clock_66);
        nrst = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ren = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 5) == 0) rcr = ~rcr;
            if ($urandom_range(0, 79) == 0) rps = ~rps;
            cycle(ren, rcr, rps);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
